register_file_mp: RTL and testbench

- Parametrised multi-port register file for the ARM pipeline core.
- Provides NUM_RD combinational read ports, two write-back ports with fixed priority, and same-cycle write-to-read bypass.
- Keeps a per-register busy scoreboard, so the hazard unit can stall on pending producers.
- Sits between ID (reads, issue) and WB (writes); replaces the single-write, negedge-write register file.

---
 rtl/rf_pkg.sv | 10 +
 rtl/rf_read_bypass.sv | 35 +++
 rtl/register_file_mp.sv | 88 ++++++++
 tb/tb_register_file_mp.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared widths and index/word types for the multi-port register file.
package rf_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 4;

  typedef logic [ADDR_W_DEF-1:0] reg_idx_t;
  typedef logic [DATA_W_DEF-1:0] word_t;

endpackage

// File: rtl/rf_read_bypass.sv
// One read port: same-cycle write-back bypass (wb1 over wb0 over storage)
// and the busy flag for the addressed register.
module rf_read_bypass #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4
) (
  input  logic [ADDR_W-1:0] i_rd_addr,
  input  logic [DATA_W-1:0] i_word,
  input  logic              i_busy,
  input  logic              i_wb0_en,
  input  logic [ADDR_W-1:0] i_wb0_addr,
  input  logic [DATA_W-1:0] i_wb0_data,
  input  logic              i_wb1_en,
  input  logic [ADDR_W-1:0] i_wb1_addr,
  input  logic [DATA_W-1:0] i_wb1_data,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_busy
);

  logic w_hit0;
  logic w_hit1;

  assign w_hit0 = i_wb0_en && (i_wb0_addr == i_rd_addr);
  assign w_hit1 = i_wb1_en && (i_wb1_addr == i_rd_addr);

  always_comb begin
    if (w_hit1)      o_rd_data = i_wb1_data;
    else if (w_hit0) o_rd_data = i_wb0_data;
    else             o_rd_data = i_word;
  end

  // A write-back landing this cycle resolves the pending producer for the reader.
  assign o_rd_busy = i_busy && !(w_hit0 || w_hit1);

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file: NUM_RD bypassed read ports, two prioritised
// write-back ports and a per-register busy scoreboard for the hazard unit.
module register_file_mp
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wb0_en,
  input  logic [ADDR_W-1:0]        wb0_addr,
  input  logic [DATA_W-1:0]        wb0_data,
  input  logic                     wb1_en,
  input  logic [ADDR_W-1:0]        wb1_addr,
  input  logic [DATA_W-1:0]        wb1_data,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr,
  input  logic                     flush
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
    $error("register_file_mp: NUM_RD must be in 1..4");
  end
  if (DATA_W < ADDR_W) begin : g_bad_data_w
    $error("register_file_mp: DATA_W < ADDR_W truncates reset values");
  end

  logic [DATA_W-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [DEPTH-1:0]  w_busy_next;

  // wb1 is written last so it overrides wb0 on an address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_data[i] <= DATA_W'(i);
    end else begin
      if (wb0_en) r_data[wb0_addr] <= wb0_data;
      if (wb1_en) r_data[wb1_addr] <= wb1_data;
    end
  end

  always_comb begin
    w_busy_next = r_busy;
    for (int unsigned r = 0; r < DEPTH; r++) begin
      if (flush)
        w_busy_next[r] = 1'b0;
      else if (issue_en && issue_addr == ADDR_W'(r))
        w_busy_next[r] = 1'b1;
      else if ((wb0_en && wb0_addr == ADDR_W'(r)) || (wb1_en && wb1_addr == ADDR_W'(r)))
        w_busy_next[r] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_next;
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    assign w_addr = rd_addr[k*ADDR_W +: ADDR_W];

    rf_read_bypass #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_rd (
      .i_rd_addr  (w_addr),
      .i_word     (r_data[w_addr]),
      .i_busy     (r_busy[w_addr]),
      .i_wb0_en   (wb0_en),
      .i_wb0_addr (wb0_addr),
      .i_wb0_data (wb0_data),
      .i_wb1_en   (wb1_en),
      .i_wb1_addr (wb1_addr),
      .i_wb1_data (wb1_data),
      .o_rd_data  (rd_data[k*DATA_W +: DATA_W]),
      .o_rd_busy  (rd_busy[k])
    );
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: directed literal checks plus randomized
// traffic compared every cycle against an array-based reference model.
`timescale 1ns/1ps
module tb_register_file_mp;

  localparam int NUM_RD = 3;
  localparam int AW     = 4;
  localparam int DW     = 32;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_RD*AW-1:0] rd_addr;
  logic [NUM_RD*DW-1:0] rd_data;
  logic [NUM_RD-1:0]    rd_busy;
  logic                 wb0_en, wb1_en, issue_en, flush;
  logic [AW-1:0]        wb0_addr, wb1_addr, issue_addr;
  logic [DW-1:0]        wb0_data, wb1_data;

  int errors = 0;
  int checks = 0;
  bit cmp_on = 1'b0;

  register_file_mp #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .NUM_RD (NUM_RD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .wb0_en     (wb0_en),
    .wb0_addr   (wb0_addr),
    .wb0_data   (wb0_data),
    .wb1_en     (wb1_en),
    .wb1_addr   (wb1_addr),
    .wb1_data   (wb1_data),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .flush      (flush)
  );

  always #5 clk = ~clk;

  // Reference model: plain arrays updated from the architectural rules.
  logic [DW-1:0] m_data [16];
  bit            m_busy [16];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        m_data[i] = DW'(i);
        m_busy[i] = 1'b0;
      end
    end else begin
      if (flush) begin
        for (int i = 0; i < 16; i++) m_busy[i] = 1'b0;
      end else begin
        if (wb0_en)   m_busy[wb0_addr]   = 1'b0;
        if (wb1_en)   m_busy[wb1_addr]   = 1'b0;
        if (issue_en) m_busy[issue_addr] = 1'b1;
      end
      if (wb0_en) m_data[wb0_addr] = wb0_data;
      if (wb1_en) m_data[wb1_addr] = wb1_data;
    end
  end

  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
    if (wb1_en && wb1_addr == a)      return wb1_data;
    else if (wb0_en && wb0_addr == a) return wb0_data;
    return m_data[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    return m_busy[a] && !((wb0_en && wb0_addr == a) || (wb1_en && wb1_addr == a));
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] pdata(input int k);
    return rd_data[k*DW +: DW];
  endfunction

  function automatic logic [AW-1:0] paddr(input int k);
    return rd_addr[k*AW +: AW];
  endfunction

  always @(negedge clk) begin
    if (cmp_on) begin
      for (int k = 0; k < NUM_RD; k++) begin
        check($sformatf("model data port%0d", k), pdata(k), exp_data(paddr(k)));
        check($sformatf("model busy port%0d", k), DW'(rd_busy[k]), DW'(exp_busy(paddr(k))));
      end
    end
  end

  task automatic idle();
    wb0_en = 0; wb1_en = 0; issue_en = 0; flush = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    rd_addr = {a2, a1, a0};
  endtask

  function automatic logic [AW-1:0] rnd_a();
    if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 3));
    return AW'($urandom_range(0, 15));
  endfunction

  initial begin
    rst = 1'b1;
    idle();
    wb0_addr = '0; wb1_addr = '0; issue_addr = '0;
    wb0_data = '0; wb1_data = '0;
    set_rd(0, 0, 0);
    tick(); tick();
    rst = 1'b0;
    cmp_on = 1'b1;

    // Three ports with a same-cycle wb1 bypass on r15.
    set_rd(0, 7, 15);
    wb1_en = 1; wb1_addr = 15; wb1_data = 32'h55;
    #1;
    check("multiport r0", pdata(0), 32'd0);
    check("multiport r7", pdata(1), 32'd7);
    check("multiport r15", pdata(2), 32'h55);
    tick(); idle();

    // Dirty r5/r15 and busy r15, then reset asynchronously mid-cycle.
    wb0_en = 1; wb0_addr = 5; wb0_data = 32'h1234;
    issue_en = 1; issue_addr = 15;
    tick(); idle();
    set_rd(5, 15, 0);
    #2 rst = 1'b1;
    #1;
    check("async rst r5", pdata(0), 32'd5);
    check("async rst r15", pdata(1), 32'd15);
    check("async rst busy r15", DW'(rd_busy[1]), 32'd0);
    for (int i = 0; i < 16; i++) begin
      rd_addr[AW-1:0] = AW'(i);
      #1;
      check($sformatf("reset value r%0d", i), pdata(0), DW'(i));
    end
    @(posedge clk); #1 rst = 1'b0;

    // Write with bypass, then read from storage.
    set_rd(3, 7, 1);
    wb0_en = 1; wb0_addr = 3; wb0_data = 32'hDEADBEEF;
    #1 check("bypass r3", pdata(0), 32'hDEADBEEF);
    tick(); idle();
    #1 check("stored r3", pdata(0), 32'hDEADBEEF);

    // Dual-write conflict on r7, then distinct addresses.
    wb0_en = 1; wb0_addr = 7; wb0_data = 32'h11;
    wb1_en = 1; wb1_addr = 7; wb1_data = 32'h22;
    #1 check("conflict bypass r7", pdata(1), 32'h22);
    tick(); idle();
    #1 check("conflict stored r7", pdata(1), 32'h22);
    wb0_en = 1; wb0_addr = 1; wb0_data = 32'hA;
    wb1_en = 1; wb1_addr = 2; wb1_data = 32'hB;
    tick(); idle();
    set_rd(1, 2, 4);
    #1;
    check("distinct r1", pdata(0), 32'hA);
    check("distinct r2", pdata(1), 32'hB);

    // Scoreboard: issue r4, then write-back clears it combinationally.
    issue_en = 1; issue_addr = 4;
    tick(); idle();
    #1 check("busy r4 after issue", DW'(rd_busy[2]), 32'd1);
    wb0_en = 1; wb0_addr = 4; wb0_data = 32'h44;
    #1 check("busy r4 same-cycle wb", DW'(rd_busy[2]), 32'd0);
    tick(); idle();
    #1 check("busy r4 after wb", DW'(rd_busy[2]), 32'd0);

    // Issue beats same-cycle write-back; flush beats issue.
    issue_en = 1; issue_addr = 9;
    wb1_en = 1; wb1_addr = 9; wb1_data = 32'h99;
    tick(); idle();
    set_rd(9, 6, 0);
    #1 check("busy r9 issue+wb", DW'(rd_busy[0]), 32'd1);
    issue_en = 1; issue_addr = 6; flush = 1;
    tick(); idle();
    for (int i = 0; i < 16; i++) begin
      rd_addr[AW-1:0] = AW'(i);
      #0.5;
      check($sformatf("flush busy r%0d", i), DW'(rd_busy[0]), 32'd0);
    end

    // Randomized traffic checked every cycle by the compare process.
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 299) == 0);
      set_rd(rnd_a(), rnd_a(), rnd_a());
      wb0_en = ($urandom_range(0, 2) != 0);
      wb0_addr = rnd_a(); wb0_data = $urandom;
      wb1_en = ($urandom_range(0, 2) == 0);
      wb1_addr = rnd_a(); wb1_data = $urandom;
      issue_en = ($urandom_range(0, 1) == 0);
      issue_addr = rnd_a();
      flush = ($urandom_range(0, 49) == 0);
    end
    @(posedge clk); #1;
    rst = 1'b0; idle();
    @(negedge clk); #1;
    cmp_on = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
